// File: rtl/dfp_arbiter.sv
// dfp_arbiter -- shares one memory request port between the icache and the
// dcache and routes address-tagged (possibly out-of-order) read responses
// back to whichever requester(s) are waiting on that address.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   i_dfp_addr/read       : icache line request          -> i_dfp_ready
//   i_dfp_raddr/rdata/rvalid : icache response
//   d_dfp_addr/read/write/wdata : dcache line request    -> d_dfp_ready
//   d_dfp_raddr/rdata/rvalid : dcache response
//   dfp_addr/read/write/wdata, dfp_ready : shared memory request port
//   dfp_raddr/rdata/rvalid : memory response, tagged by address
//
// Configuration
//   DFP_ARB_RR_EN defined   : round-robin between the two requesters
//   DFP_ARB_RR_EN undefined : fixed priority, dcache over icache
//
// Each requester owns one outstanding-read record (valid + address). A
// requester with a live record is not eligible, so a response and a new
// grant can never hit the same requester in the same cycle.
module dfp_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_dfp_addr,
  input  logic         i_dfp_read,
  output logic         i_dfp_ready,
  output logic [31:0]  i_dfp_raddr,
  output logic [255:0] i_dfp_rdata,
  output logic         i_dfp_rvalid,
  input  logic [31:0]  d_dfp_addr,
  input  logic         d_dfp_read,
  input  logic         d_dfp_write,
  input  logic [255:0] d_dfp_wdata,
  output logic         d_dfp_ready,
  output logic [31:0]  d_dfp_raddr,
  output logic [255:0] d_dfp_rdata,
  output logic         d_dfp_rvalid,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  output logic         dfp_write,
  output logic [255:0] dfp_wdata,
  input  logic         dfp_ready,
  input  logic [31:0]  dfp_raddr,
  input  logic [255:0] dfp_rdata,
  input  logic         dfp_rvalid
);

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  logic        i_out_valid_q, i_out_valid_d;
  logic        d_out_valid_q, d_out_valid_d;
  logic [31:0] i_out_addr_q,  i_out_addr_d;
  logic [31:0] d_out_addr_q,  d_out_addr_d;
  // A grant that was offered but not accepted is remembered so it cannot
  // migrate to the other requester while memory stalls.
  logic        hold_valid_q,  hold_valid_d;
  logic        hold_sel_q,    hold_sel_d;
`ifdef DFP_ARB_RR_EN
  logic        rr_ptr_q,      rr_ptr_d;
`endif

  logic i_elig, d_elig;
  logic gnt_valid, gnt_sel, accept;

  always_comb begin
    i_elig    = i_dfp_read & ~i_out_valid_q;
    d_elig    = (d_dfp_read | d_dfp_write) & ~d_out_valid_q;
    gnt_valid = 1'b0;
    gnt_sel   = REQ_I;
    if (!rst) begin
      if (hold_valid_q && (hold_sel_q ? d_elig : i_elig)) begin
        gnt_valid = 1'b1;
        gnt_sel   = hold_sel_q;
      end
`ifdef DFP_ARB_RR_EN
      else if (rr_ptr_q ? d_elig : i_elig) begin
        gnt_valid = 1'b1;
        gnt_sel   = rr_ptr_q;
      end else if (rr_ptr_q ? i_elig : d_elig) begin
        gnt_valid = 1'b1;
        gnt_sel   = ~rr_ptr_q;
      end
`else
      else if (d_elig) begin
        gnt_valid = 1'b1;
        gnt_sel   = REQ_D;
      end else if (i_elig) begin
        gnt_valid = 1'b1;
        gnt_sel   = REQ_I;
      end
`endif
    end
    accept = gnt_valid & dfp_ready;
  end

  // Request mux and handshakes; a dcache read+write is issued as a write.
  always_comb begin
    dfp_addr    = '0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    if (gnt_valid) begin
      if (gnt_sel == REQ_D) begin
        dfp_addr  = d_dfp_addr;
        dfp_write = d_dfp_write;
        dfp_read  = d_dfp_read & ~d_dfp_write;
        dfp_wdata = d_dfp_wdata;
      end else begin
        dfp_addr  = i_dfp_addr;
        dfp_read  = 1'b1;
      end
    end
    i_dfp_ready = accept & (gnt_sel == REQ_I);
    d_dfp_ready = accept & (gnt_sel == REQ_D);
  end

  // Response routing: every matching record sees the same response.
  always_comb begin
    i_dfp_rvalid = ~rst & dfp_rvalid & i_out_valid_q & (i_out_addr_q == dfp_raddr);
    d_dfp_rvalid = ~rst & dfp_rvalid & d_out_valid_q & (d_out_addr_q == dfp_raddr);
    i_dfp_raddr  = rst ? '0 : dfp_raddr;
    i_dfp_rdata  = rst ? '0 : dfp_rdata;
    d_dfp_raddr  = rst ? '0 : dfp_raddr;
    d_dfp_rdata  = rst ? '0 : dfp_rdata;
  end

  always_comb begin
    i_out_valid_d = i_out_valid_q;
    i_out_addr_d  = i_out_addr_q;
    d_out_valid_d = d_out_valid_q;
    d_out_addr_d  = d_out_addr_q;
    if (i_dfp_rvalid) i_out_valid_d = 1'b0;
    if (d_dfp_rvalid) d_out_valid_d = 1'b0;
    if (i_dfp_ready) begin
      i_out_valid_d = 1'b1;
      i_out_addr_d  = i_dfp_addr;
    end
    if (d_dfp_ready && !d_dfp_write) begin
      d_out_valid_d = 1'b1;
      d_out_addr_d  = d_dfp_addr;
    end
    hold_valid_d = gnt_valid & ~dfp_ready;
    hold_sel_d   = gnt_sel;
`ifdef DFP_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (accept && (gnt_sel == rr_ptr_q)) rr_ptr_d = ~rr_ptr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_out_valid_q <= 1'b0;
      d_out_valid_q <= 1'b0;
      i_out_addr_q  <= '0;
      d_out_addr_q  <= '0;
      hold_valid_q  <= 1'b0;
      hold_sel_q    <= REQ_I;
`ifdef DFP_ARB_RR_EN
      rr_ptr_q      <= REQ_I;
`endif
    end else begin
      i_out_valid_q <= i_out_valid_d;
      d_out_valid_q <= d_out_valid_d;
      i_out_addr_q  <= i_out_addr_d;
      d_out_addr_q  <= d_out_addr_d;
      hold_valid_q  <= hold_valid_d;
      hold_sel_q    <= hold_sel_d;
`ifdef DFP_ARB_RR_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: doc/dfp_arbiter.md
DFP_ARBITER -- requirements
Module: dfp_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 i_dfp_addr  input  32  icache line address, 32-byte aligned; i_dfp_read input 1 icache read request; i_dfp_ready output 1 icache request accepted this cycle.
REQ-004 i_dfp_raddr  output  32, i_dfp_rdata  output  256, i_dfp_rvalid  output  1  icache response.
REQ-005 d_dfp_addr  input  32, d_dfp_read  input  1, d_dfp_write  input  1, d_dfp_wdata  input  256, d_dfp_ready  output  1  dcache request port.
REQ-006 d_dfp_raddr  output  32, d_dfp_rdata  output  256, d_dfp_rvalid  output  1  dcache response.
REQ-007 dfp_addr  output  32, dfp_read  output  1, dfp_write  output  1, dfp_wdata  output  256  shared memory request; dfp_ready input 1 memory accepts request.
REQ-008 dfp_raddr  input  32, dfp_rdata  input  256, dfp_rvalid  input  1  memory response, possibly out of order, tagged by address.

Function
REQ-009 Each requester SHALL have one record: out_valid (1 bit), out_addr (32 bits).
REQ-010 A requester is eligible when its read or write is high and its registered out_valid is 0.
REQ-011 A requester with read and write both high is illegal; the block SHALL treat it as a write.
REQ-012 Grant SHALL be combinational; at most one requester is granted per cycle.
REQ-013 The granted requester's addr/read/write/wdata SHALL drive dfp_*; with no grant, dfp_read = dfp_write = 0 and dfp_addr/dfp_wdata = 0.
REQ-014 x_dfp_ready SHALL equal granted(x) AND dfp_ready, and is 0 for non-granted requesters.
REQ-015 A granted requester SHALL hold the grant until accepted; grant never moves to another requester while the current one remains eligible and dfp_ready is 0.
REQ-016 On accepted read, the block SHALL set out_valid <= 1 and out_addr <= the request address. Accepted writes SHALL create no record and receive no response.
REQ-017 On dfp_rvalid, every requester with out_valid = 1 and out_addr == dfp_raddr SHALL see x_dfp_rvalid = 1 in the same cycle, with raddr/rdata passed through. Its out_valid SHALL clear at the next edge.
REQ-018 If both records match one response, both SHALL receive it in the same cycle.
REQ-019 A dfp_rvalid matching no record SHALL be dropped with no upstream rvalid.
REQ-020 x_dfp_rvalid SHALL be 0 whenever dfp_rvalid is 0. rdata/raddr are don't-care then, but driven from dfp_*.
REQ-021 A response and a new grant for the same requester in one cycle cannot occur, because eligibility uses registered out_valid (REQ-010).
REQ-022 A response to one requester and an accepted request from the other in the same cycle SHALL both take effect.

Reset
REQ-023 On rst, out_valid SHALL clear for both requesters, out_addr SHALL be 0, and the round-robin pointer SHALL be icache.
REQ-024 In the reset cycle all outputs SHALL be 0 and no grant is given.
REQ-025 A response arriving after reset for a pre-reset read SHALL be dropped per REQ-019.

Configuration
REQ-026 Macro DFP_ARB_RR_EN defined: round-robin arbitration. The pointer names the preferred requester. It SHALL toggle to the other requester after each accepted request from the preferred one. It is unchanged when the non-preferred requester is accepted or no request is accepted.
REQ-027 Macro DFP_ARB_RR_EN undefined: fixed priority, dcache over icache. No pointer register.

Verification
REQ-028 Both eligible, dfp_ready=1, RR enabled, after reset: icache 0x100 granted in cycle 0, dcache 0x200 in cycle 1. With RR disabled, dcache is granted first.
REQ-029 Icache read 0x40 accepted, then dfp_rvalid with raddr 0x40 and rdata pattern A5: i_dfp_rvalid=1 in the same cycle with data A5, d_dfp_rvalid=0, and the icache is eligible again next cycle.
REQ-030 Dcache write 0x80 with dfp_ready held 0 for 3 cycles: dfp_write stays 1 and d_dfp_ready=0 for 3 cycles. On the cycle dfp_ready rises, d_dfp_ready=1, and no record is created.
REQ-031 Both read 0x300 and both are accepted: a single dfp_rvalid for 0x300 asserts both i_dfp_rvalid and d_dfp_rvalid, and both records clear.
REQ-032 Icache read 0x500 outstanding, rst pulsed, then dfp_rvalid 0x500: no upstream rvalid.
REQ-033 Responses returned out of order (dcache 0x600 before icache 0x700): each response goes only to its owner.
